// File: rtl/ysyx_23060208_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_23060208_pkg: address map, response codes and FSM encodings      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package ysyx_23060208_pkg;

    localparam int          c_map_slaves  = 3;

    localparam logic [31:0] c_sram_base   = 32'h8000_0000;
    localparam logic [31:0] c_sram_limit  = 32'h87FF_FFFF;
    localparam logic [31:0] c_uart_base   = 32'hA000_03F8;
    localparam logic [31:0] c_uart_limit  = 32'hA000_03FF;
    localparam logic [31:0] c_clint_base  = 32'hA000_0048;
    localparam logic [31:0] c_clint_limit = 32'hA000_004F;

    localparam logic [1:0]  c_resp_okay   = 2'b00;
    localparam logic [1:0]  c_resp_decerr = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_ERR  = 2'd3
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2,
        W_ERR  = 2'd3
    } wr_state_t;

    function automatic logic addr_in_range(input logic [31:0] a,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060208_xbar_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_23060208_xbar_decode: address to one-hot slave select plus miss  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ysyx_23060208_xbar_decode
    import ysyx_23060208_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NS         = 3
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [NS-1:0]         o_target,
    output logic                  o_miss
);

    logic [31:0]             w_addr;
    logic [c_map_slaves-1:0] w_map;

    assign w_addr   = 32'(i_addr);
    assign w_map[0] = addr_in_range(w_addr, c_sram_base,  c_sram_limit);
    assign w_map[1] = addr_in_range(w_addr, c_uart_base,  c_uart_limit);
    assign w_map[2] = addr_in_range(w_addr, c_clint_base, c_clint_limit);

    // Slots beyond the fixed address map never decode.
    for (genvar i = 0; i < NS; i++) begin : g_target
        if (i < c_map_slaves) begin : g_mapped
            assign o_target[i] = w_map[i];
        end else begin : g_unmapped
            assign o_target[i] = 1'b0;
        end
    end

    assign o_miss = ~|o_target;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060208_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_23060208_xbar: 1-master / NS-slave AXI-lite crossbar            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ysyx_23060208_xbar
    import ysyx_23060208_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NS         = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      m_awaddr,
    input  logic                       m_awvalid,
    output logic                       m_awready,
    input  logic [DATA_WIDTH-1:0]      m_wdata,
    input  logic [DATA_WIDTH/8-1:0]    m_wstrb,
    input  logic                       m_wvalid,
    output logic                       m_wready,
    output logic [1:0]                 m_bresp,
    output logic                       m_bvalid,
    input  logic                       m_bready,
    input  logic [ADDR_WIDTH-1:0]      m_araddr,
    input  logic                       m_arvalid,
    output logic                       m_arready,
    output logic [DATA_WIDTH-1:0]      m_rdata,
    output logic [1:0]                 m_rresp,
    output logic                       m_rvalid,
    input  logic                       m_rready,
    output logic [NS*ADDR_WIDTH-1:0]   s_awaddr,
    output logic [NS-1:0]              s_awvalid,
    input  logic [NS-1:0]              s_awready,
    output logic [NS*DATA_WIDTH-1:0]   s_wdata,
    output logic [NS*DATA_WIDTH/8-1:0] s_wstrb,
    output logic [NS-1:0]              s_wvalid,
    input  logic [NS-1:0]              s_wready,
    input  logic [NS*2-1:0]            s_bresp,
    input  logic [NS-1:0]              s_bvalid,
    output logic [NS-1:0]              s_bready,
    output logic [NS*ADDR_WIDTH-1:0]   s_araddr,
    output logic [NS-1:0]              s_arvalid,
    input  logic [NS-1:0]              s_arready,
    input  logic [NS*DATA_WIDTH-1:0]   s_rdata,
    input  logic [NS*2-1:0]            s_rresp,
    input  logic [NS-1:0]              s_rvalid,
    output logic [NS-1:0]              s_rready
);

    localparam int c_sw = DATA_WIDTH / 8;

    logic [NS-1:0] w_ar_target, w_aw_target;
    logic          w_ar_miss,   w_aw_miss;

    ysyx_23060208_xbar_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NS(NS)) u_ar_decode (
        .i_addr   (m_araddr),
        .o_target (w_ar_target),
        .o_miss   (w_ar_miss)
    );

    ysyx_23060208_xbar_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NS(NS)) u_aw_decode (
        .i_addr   (m_awaddr),
        .o_target (w_aw_target),
        .o_miss   (w_aw_miss)
    );

    // ---------------- read channel ----------------
    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [NS-1:0]         r_rsel;
    logic                  w_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_raddr    <= '0;
            r_rsel     <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (r_rd_state == R_IDLE && m_arvalid) begin
                r_raddr <= m_araddr;
                r_rsel  <= w_ar_target;
            end
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rvalid       = 1'b0;
        m_arready      = 1'b0;
        m_rresp        = c_resp_okay;
        m_rdata        = '0;
        s_arvalid      = '0;
        s_araddr       = '0;
        s_rready       = '0;
        case (r_rd_state)
            R_IDLE: begin
                m_arready = 1'b1;
                if (m_arvalid) w_rd_state_nxt = w_ar_miss ? R_ERR : R_ADDR;
            end
            R_ADDR: begin
                s_arvalid = r_rsel;
                for (int i = 0; i < NS; i++)
                    if (r_rsel[i]) s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] = r_raddr;
                if (|(s_arready & r_rsel)) w_rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                for (int i = 0; i < NS; i++) begin
                    if (r_rsel[i]) begin
                        m_rdata     = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                        m_rresp     = s_rresp[i*2 +: 2];
                        w_rvalid    = s_rvalid[i];
                        s_rready[i] = m_rready;
                    end
                end
                if (w_rvalid && m_rready) w_rd_state_nxt = R_IDLE;
            end
            R_ERR: begin
                w_rvalid = 1'b1;
                m_rresp  = c_resp_decerr;
                if (m_rready) w_rd_state_nxt = R_IDLE;
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
        // Valid/ready lines are held low for the whole reset window.
        m_rvalid = w_rvalid && !rst;
        if (rst) begin
            s_arvalid = '0;
            s_rready  = '0;
        end
    end

    // ---------------- write channel ----------------
    wr_state_t             r_wr_state, w_wr_state_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_sw-1:0]       r_wstrb;
    logic [NS-1:0]         r_wsel;
    logic                  r_aw_done, r_w_done;
    logic                  w_aw_done_nxt, w_w_done_nxt;
    logic                  w_aw_now, w_w_now;
    logic                  w_bvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wsel     <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
            if (r_wr_state == W_IDLE && m_awvalid && m_wvalid) begin
                r_waddr <= m_awaddr;
                r_wdata <= m_wdata;
                r_wstrb <= m_wstrb;
                r_wsel  <= w_aw_target;
            end
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_done_nxt  = 1'b0;
        w_w_done_nxt   = 1'b0;
        w_aw_now       = 1'b0;
        w_w_now        = 1'b0;
        w_bvalid       = 1'b0;
        m_awready      = 1'b0;
        m_wready       = 1'b0;
        m_bresp        = c_resp_okay;
        s_awvalid      = '0;
        s_awaddr       = '0;
        s_wvalid       = '0;
        s_wdata        = '0;
        s_wstrb        = '0;
        s_bready       = '0;
        case (r_wr_state)
            W_IDLE: begin
                if (m_awvalid && m_wvalid) begin
                    m_awready      = 1'b1;
                    m_wready       = 1'b1;
                    w_wr_state_nxt = w_aw_miss ? W_ERR : W_ADDR;
                end
            end
            W_ADDR: begin
                for (int i = 0; i < NS; i++) begin
                    if (r_wsel[i] && !r_aw_done) begin
                        s_awvalid[i]                         = 1'b1;
                        s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH] = r_waddr;
                    end
                    if (r_wsel[i] && !r_w_done) begin
                        s_wvalid[i]                          = 1'b1;
                        s_wdata[i*DATA_WIDTH +: DATA_WIDTH]  = r_wdata;
                        s_wstrb[i*c_sw +: c_sw]              = r_wstrb;
                    end
                end
                w_aw_now = r_aw_done || (|(s_awready & r_wsel));
                w_w_now  = r_w_done  || (|(s_wready  & r_wsel));
                if (w_aw_now && w_w_now) begin
                    w_wr_state_nxt = W_RESP;
                end else begin
                    w_aw_done_nxt = w_aw_now;
                    w_w_done_nxt  = w_w_now;
                end
            end
            W_RESP: begin
                for (int i = 0; i < NS; i++) begin
                    if (r_wsel[i]) begin
                        m_bresp     = s_bresp[i*2 +: 2];
                        w_bvalid    = s_bvalid[i];
                        s_bready[i] = m_bready;
                    end
                end
                if (w_bvalid && m_bready) w_wr_state_nxt = W_IDLE;
            end
            W_ERR: begin
                w_bvalid = 1'b1;
                m_bresp  = c_resp_decerr;
                if (m_bready) w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
        m_bvalid = w_bvalid && !rst;
        if (rst) begin
            s_awvalid = '0;
            s_wvalid  = '0;
            s_bready  = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060208_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_23060208_xbar: directed self-checking bench for the crossbar  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ysyx_23060208_xbar;

    logic        clk;
    logic        rst;
    logic [31:0] m_awaddr;
    logic        m_awvalid, m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid, m_rready;
    logic [95:0] s_awaddr;
    logic [2:0]  s_awvalid, s_awready;
    logic [95:0] s_wdata;
    logic [11:0] s_wstrb;
    logic [2:0]  s_wvalid, s_wready;
    logic [5:0]  s_bresp;
    logic [2:0]  s_bvalid, s_bready;
    logic [95:0] s_araddr;
    logic [2:0]  s_arvalid, s_arready;
    logic [95:0] s_rdata;
    logic [5:0]  s_rresp;
    logic [2:0]  s_rvalid, s_rready;

    int checks = 0;
    int errors = 0;
    int arv_cnt[3];
    int awv_cnt[3];
    int wv_cnt[3];
    int arv_base[3];
    int awv_base[3];
    int wv_base[3];

    ysyx_23060208_xbar #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NS(3)) dut (
        .clk(clk), .rst(rst),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-slave count of cycles each valid was high.
    initial begin
        for (int i = 0; i < 3; i++) begin
            arv_cnt[i] = 0; awv_cnt[i] = 0; wv_cnt[i] = 0;
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (s_arvalid[i]) arv_cnt[i]++;
            if (s_awvalid[i]) awv_cnt[i]++;
            if (s_wvalid[i])  wv_cnt[i]++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snapshot;
        for (int i = 0; i < 3; i++) begin
            arv_base[i] = arv_cnt[i]; awv_base[i] = awv_cnt[i]; wv_base[i] = wv_cnt[i];
        end
    endtask

    task automatic drive_idle;
        m_awaddr = '0; m_awvalid = 0; m_wdata = '0; m_wstrb = '0; m_wvalid = 0;
        m_bready = 0;  m_araddr = '0; m_arvalid = 0; m_rready = 0;
        s_awready = '0; s_wready = '0; s_bresp = '0; s_bvalid = '0;
        s_arready = '0; s_rdata = '0; s_rresp = '0; s_rvalid = '0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick; tick;
        checks++; if (s_arvalid !== 3'b000 || s_awvalid !== 3'b000 || s_wvalid !== 3'b000) begin
            errors++; $display("FAIL reset_s_valid: ar=%b aw=%b w=%b expected 000", s_arvalid, s_awvalid, s_wvalid); end
        checks++; if (s_rready !== 3'b000 || s_bready !== 3'b000) begin
            errors++; $display("FAIL reset_s_ready: r=%b b=%b expected 000", s_rready, s_bready); end
        checks++; if (m_rvalid !== 1'b0 || m_bvalid !== 1'b0) begin
            errors++; $display("FAIL reset_m_valid: rvalid=%b bvalid=%b expected 0", m_rvalid, m_bvalid); end
        rst = 0;
        tick;
        checks++; if (m_arready !== 1'b1) begin
            errors++; $display("FAIL reset_arready: got %b expected 1", m_arready); end
        checks++; if (m_awready !== 1'b0 || m_wready !== 1'b0) begin
            errors++; $display("FAIL idle_awready: aw=%b w=%b expected 0", m_awready, m_wready); end
    endtask

    task automatic test_sram_read;
        snapshot;
        m_araddr = 32'h8000_0010; m_arvalid = 1;
        #1;
        checks++; if (m_arready !== 1'b1 || s_arvalid !== 3'b000) begin
            errors++; $display("FAIL rd_handshake: arready=%b s_arvalid=%b expected 1/000", m_arready, s_arvalid); end
        tick;
        m_arvalid = 0;
        #1;
        checks++; if (s_arvalid !== 3'b001 || s_araddr[31:0] !== 32'h8000_0010) begin
            errors++; $display("FAIL rd_addr_phase: s_arvalid=%b addr=%h expected 001/80000010", s_arvalid, s_araddr[31:0]); end
        checks++; if (m_arready !== 1'b0) begin
            errors++; $display("FAIL rd_busy_arready: got %b expected 0", m_arready); end
        s_arready = 3'b001;
        tick;
        s_arready = 3'b000;
        #1;
        checks++; if (s_arvalid !== 3'b000 || m_rvalid !== 1'b0) begin
            errors++; $display("FAIL rd_data_wait: s_arvalid=%b m_rvalid=%b expected 000/0", s_arvalid, m_rvalid); end
        s_rdata[31:0] = 32'hDEAD_BEEF; s_rresp[1:0] = 2'b00; s_rvalid = 3'b001; m_rready = 1;
        #1;
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hDEAD_BEEF || m_rresp !== 2'b00) begin
            errors++; $display("FAIL rd_data: valid=%b data=%h resp=%b expected 1/deadbeef/00", m_rvalid, m_rdata, m_rresp); end
        checks++; if (s_rready !== 3'b001) begin
            errors++; $display("FAIL rd_rready: got %b expected 001", s_rready); end
        tick;
        s_rvalid = 3'b000; m_rready = 0; s_rdata = '0;
        #1;
        checks++; if (m_rvalid !== 1'b0 || m_arready !== 1'b1) begin
            errors++; $display("FAIL rd_back_idle: rvalid=%b arready=%b expected 0/1", m_rvalid, m_arready); end
        checks++; if (arv_cnt[0] - arv_base[0] !== 1 || arv_cnt[1] - arv_base[1] !== 0 || arv_cnt[2] - arv_base[2] !== 0) begin
            errors++; $display("FAIL rd_arvalid_count: got %0d/%0d/%0d expected 1/0/0",
                arv_cnt[0] - arv_base[0], arv_cnt[1] - arv_base[1], arv_cnt[2] - arv_base[2]); end
    endtask

    task automatic test_uart_write;
        snapshot;
        m_awaddr = 32'hA000_03F8; m_awvalid = 1; m_wdata = 32'h41; m_wstrb = 4'b0001; m_wvalid = 1;
        #1;
        checks++; if (m_awready !== 1'b1 || m_wready !== 1'b1) begin
            errors++; $display("FAIL wr_handshake: aw=%b w=%b expected 1/1", m_awready, m_wready); end
        tick;
        m_awvalid = 0; m_wvalid = 0;
        #1;
        checks++; if (s_awvalid !== 3'b010 || s_wvalid !== 3'b010) begin
            errors++; $display("FAIL wr_addr_phase: aw=%b w=%b expected 010/010", s_awvalid, s_wvalid); end
        checks++; if (s_awaddr[63:32] !== 32'hA000_03F8 || s_wdata[63:32] !== 32'h41 || s_wstrb[7:4] !== 4'b0001) begin
            errors++; $display("FAIL wr_payload: addr=%h data=%h strb=%b expected a00003f8/41/0001",
                s_awaddr[63:32], s_wdata[63:32], s_wstrb[7:4]); end
        s_awready = 3'b010;
        tick;
        s_awready = 3'b000;
        #1;
        checks++; if (s_awvalid !== 3'b000 || s_wvalid !== 3'b010) begin
            errors++; $display("FAIL wr_aw_done: aw=%b w=%b expected 000/010", s_awvalid, s_wvalid); end
        tick;
        s_wready = 3'b010;
        tick;
        s_wready = 3'b000;
        #1;
        checks++; if (s_awvalid !== 3'b000 || s_wvalid !== 3'b000 || m_bvalid !== 1'b0) begin
            errors++; $display("FAIL wr_resp_wait: aw=%b w=%b bvalid=%b expected 000/000/0", s_awvalid, s_wvalid, m_bvalid); end
        s_bvalid = 3'b010; s_bresp[3:2] = 2'b00; m_bready = 1;
        #1;
        checks++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b00 || s_bready !== 3'b010) begin
            errors++; $display("FAIL wr_resp: bvalid=%b bresp=%b bready=%b expected 1/00/010", m_bvalid, m_bresp, s_bready); end
        tick;
        s_bvalid = 3'b000; m_bready = 0;
        #1;
        checks++; if (m_bvalid !== 1'b0) begin
            errors++; $display("FAIL wr_back_idle: bvalid=%b expected 0", m_bvalid); end
        checks++; if (awv_cnt[1] - awv_base[1] !== 1 || wv_cnt[1] - wv_base[1] !== 3 ||
                      awv_cnt[0] - awv_base[0] !== 0 || awv_cnt[2] - awv_base[2] !== 0) begin
            errors++; $display("FAIL wr_pulse_count: aw1=%0d w1=%0d aw0=%0d aw2=%0d expected 1/3/0/0",
                awv_cnt[1] - awv_base[1], wv_cnt[1] - wv_base[1], awv_cnt[0] - awv_base[0], awv_cnt[2] - awv_base[2]); end
    endtask

    task automatic test_read_miss;
        snapshot;
        m_araddr = 32'h1000_0000; m_arvalid = 1;
        tick;
        m_arvalid = 0;
        #1;
        checks++; if (s_arvalid !== 3'b000 || m_rvalid !== 1'b1 || m_rresp !== 2'b11 || m_rdata !== 32'h0) begin
            errors++; $display("FAIL rd_miss: s_arvalid=%b rvalid=%b resp=%b data=%h expected 000/1/11/0",
                s_arvalid, m_rvalid, m_rresp, m_rdata); end
        tick;
        checks++; if (m_rvalid !== 1'b1 || m_arready !== 1'b0) begin
            errors++; $display("FAIL rd_miss_hold: rvalid=%b arready=%b expected 1/0", m_rvalid, m_arready); end
        m_rready = 1;
        tick;
        m_rready = 0;
        #1;
        checks++; if (m_rvalid !== 1'b0 || m_arready !== 1'b1) begin
            errors++; $display("FAIL rd_miss_done: rvalid=%b arready=%b expected 0/1", m_rvalid, m_arready); end
        checks++; if (arv_cnt[0] + arv_cnt[1] + arv_cnt[2] - arv_base[0] - arv_base[1] - arv_base[2] !== 0) begin
            errors++; $display("FAIL rd_miss_no_slave: arvalid cycles=%0d expected 0",
                arv_cnt[0] + arv_cnt[1] + arv_cnt[2] - arv_base[0] - arv_base[1] - arv_base[2]); end
    endtask

    task automatic test_write_miss;
        m_awaddr = 32'h0000_0000; m_awvalid = 1; m_wdata = 32'h5555_5555; m_wstrb = 4'hF; m_wvalid = 1;
        tick;
        m_awvalid = 0; m_wvalid = 0;
        #1;
        checks++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b11 || s_awvalid !== 3'b000 || s_wvalid !== 3'b000) begin
            errors++; $display("FAIL wr_miss: bvalid=%b bresp=%b aw=%b w=%b expected 1/11/000/000",
                m_bvalid, m_bresp, s_awvalid, s_wvalid); end
        m_bready = 1;
        tick;
        m_bready = 0;
        #1;
        checks++; if (m_bvalid !== 1'b0) begin
            errors++; $display("FAIL wr_miss_done: bvalid=%b expected 0", m_bvalid); end
    endtask

    task automatic test_concurrent;
        m_araddr = 32'hA000_0048; m_arvalid = 1;
        m_awaddr = 32'h8000_0000; m_awvalid = 1; m_wdata = 32'h1234_5678; m_wstrb = 4'hF; m_wvalid = 1;
        tick;
        m_arvalid = 0; m_awvalid = 0; m_wvalid = 0;
        #1;
        checks++; if (s_arvalid !== 3'b100 || s_awvalid !== 3'b001 || s_wvalid !== 3'b001) begin
            errors++; $display("FAIL cc_addr: ar=%b aw=%b w=%b expected 100/001/001", s_arvalid, s_awvalid, s_wvalid); end
        checks++; if (s_araddr[95:64] !== 32'hA000_0048 || s_awaddr[31:0] !== 32'h8000_0000 || s_wdata[31:0] !== 32'h1234_5678) begin
            errors++; $display("FAIL cc_payload: ar=%h aw=%h wd=%h expected a0000048/80000000/12345678",
                s_araddr[95:64], s_awaddr[31:0], s_wdata[31:0]); end
        s_arready = 3'b100; s_awready = 3'b001; s_wready = 3'b001;
        tick;
        s_arready = 3'b000; s_awready = 3'b000; s_wready = 3'b000;
        // Decoy data on the non-target slices exposes any cross-routing.
        s_rdata = {32'hCAFE_0048, 32'h0, 32'h1111_1111}; s_rresp = 6'b00_00_10; s_rvalid = 3'b100;
        s_bresp = 6'b10_00_01; s_bvalid = 3'b001;
        m_rready = 1; m_bready = 1;
        #1;
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hCAFE_0048 || m_rresp !== 2'b00 || s_rready !== 3'b100) begin
            errors++; $display("FAIL cc_read: valid=%b data=%h resp=%b rready=%b expected 1/cafe0048/00/100",
                m_rvalid, m_rdata, m_rresp, s_rready); end
        checks++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b01 || s_bready !== 3'b001) begin
            errors++; $display("FAIL cc_write: bvalid=%b bresp=%b bready=%b expected 1/01/001", m_bvalid, m_bresp, s_bready); end
        tick;
        s_rvalid = '0; s_bvalid = '0; s_rdata = '0; s_rresp = '0; s_bresp = '0; m_rready = 0; m_bready = 0;
        #1;
        checks++; if (m_rvalid !== 1'b0 || m_bvalid !== 1'b0 || m_arready !== 1'b1) begin
            errors++; $display("FAIL cc_done: rvalid=%b bvalid=%b arready=%b expected 0/0/1", m_rvalid, m_bvalid, m_arready); end
    endtask

    task automatic test_reset_mid_read;
        m_araddr = 32'h8000_0020; m_arvalid = 1;
        tick;
        m_arvalid = 0; s_arready = 3'b001;
        tick;
        s_arready = 3'b000; s_rdata[31:0] = 32'h7777_7777; s_rvalid = 3'b001; m_rready = 0;
        #1;
        checks++; if (m_rvalid !== 1'b1) begin
            errors++; $display("FAIL rst_pre: rvalid=%b expected 1", m_rvalid); end
        rst = 1;
        #1;
        checks++; if (m_rvalid !== 1'b0 || s_rready !== 3'b000) begin
            errors++; $display("FAIL rst_during: rvalid=%b rready=%b expected 0/000", m_rvalid, s_rready); end
        tick;
        rst = 0;
        #1;
        checks++; if (m_rvalid !== 1'b0 || s_arvalid !== 3'b000 || m_arready !== 1'b1) begin
            errors++; $display("FAIL rst_after: rvalid=%b arvalid=%b arready=%b expected 0/000/1", m_rvalid, s_arvalid, m_arready); end
        s_rvalid = '0; s_rdata = '0;
        m_araddr = 32'h8000_0030; m_arvalid = 1;
        tick;
        m_arvalid = 0;
        #1;
        checks++; if (s_arvalid !== 3'b001 || s_araddr[31:0] !== 32'h8000_0030) begin
            errors++; $display("FAIL rst_reread_addr: arvalid=%b addr=%h expected 001/80000030", s_arvalid, s_araddr[31:0]); end
        s_arready = 3'b001;
        tick;
        s_arready = 3'b000; s_rdata[31:0] = 32'h0BAD_F00D; s_rvalid = 3'b001; m_rready = 1;
        #1;
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL rst_reread_data: valid=%b data=%h expected 1/0badf00d", m_rvalid, m_rdata); end
        tick;
        s_rvalid = '0; s_rdata = '0; m_rready = 0;
    endtask

    task automatic test_aw_wait_w;
        m_awaddr = 32'h8000_0100; m_awvalid = 1; m_wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (m_awready !== 1'b0 || m_wready !== 1'b0 || s_awvalid !== 3'b000) begin
                errors++; $display("FAIL aw_wait_%0d: awready=%b wready=%b s_aw=%b expected 0/0/000",
                    k, m_awready, m_wready, s_awvalid); end
            tick;
        end
        m_wvalid = 1; m_wdata = 32'hA5A5_0001; m_wstrb = 4'b1100;
        #1;
        checks++; if (m_awready !== 1'b1 || m_wready !== 1'b1) begin
            errors++; $display("FAIL aw_wait_join: awready=%b wready=%b expected 1/1", m_awready, m_wready); end
        tick;
        m_awvalid = 0; m_wvalid = 0;
        #1;
        checks++; if (s_awvalid !== 3'b001 || s_wvalid !== 3'b001 || s_wstrb[3:0] !== 4'b1100) begin
            errors++; $display("FAIL aw_wait_fwd: aw=%b w=%b strb=%b expected 001/001/1100", s_awvalid, s_wvalid, s_wstrb[3:0]); end
        s_awready = 3'b001; s_wready = 3'b001;
        tick;
        s_awready = '0; s_wready = '0; s_bvalid = 3'b001; s_bresp = '0; m_bready = 1;
        #1;
        checks++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b00) begin
            errors++; $display("FAIL aw_wait_resp: bvalid=%b bresp=%b expected 1/00", m_bvalid, m_bresp); end
        tick;
        s_bvalid = '0; m_bready = 0;
    endtask

    initial begin
        drive_idle;
        test_reset;
        test_sram_read;
        test_uart_write;
        test_read_miss;
        test_write_miss;
        test_concurrent;
        test_reset_mid_read;
        test_aw_wait_w;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_23060208_xbar.md
YSYX_23060208_XBAR -- requirements
Module: ysyx_23060208_xbar

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width.
REQ-002 Parameter ADDR_WIDTH, default 32: address bus width.
REQ-003 Parameter NS, default 3: slave count (0 = SRAM, 1 = UART, 2 = CLINT).
REQ-004 Signal clk  in  1  clock; all state changes on its rising edge.
REQ-005 Signal rst  in  1  reset, synchronous, active-high.
REQ-006 Master AW bundle: m_awaddr in ADDR_WIDTH, m_awvalid in 1, m_awready out 1.
REQ-007 Master W bundle: m_wdata in DATA_WIDTH, m_wstrb in DATA_WIDTH/8, m_wvalid in 1, m_wready out 1.
REQ-008 Master B bundle: m_bresp out 2, m_bvalid out 1, m_bready in 1.
REQ-009 Master AR bundle: m_araddr in ADDR_WIDTH, m_arvalid in 1, m_arready out 1.
REQ-010 Master R bundle: m_rdata out DATA_WIDTH, m_rresp out 2, m_rvalid out 1, m_rready in 1.
REQ-011 Slave bundles: each signal above mirrored as s_* with opposite direction, packed NS-wide (slave i in slice i).

Function
REQ-012 Decode: [0x8000_0000, 0x87FF_FFFF] -> slave 0; [0xA000_03F8, 0xA000_03FF] -> slave 1; [0xA000_0048, 0xA000_004F] -> slave 2; otherwise miss.
REQ-013 Read FSM states: R_IDLE, R_ADDR, R_DATA, R_ERR; read and write FSMs run independently and concurrently.
REQ-014 R_IDLE: m_arready=1; on m_arvalid, latch address and target; hit -> R_ADDR, miss -> R_ERR.
REQ-015 R_ADDR: s_arvalid[t]=1 with latched address until s_arready[t]; then R_DATA.
REQ-016 R_DATA: s_rdata/rresp/rvalid[t] routed to master, m_rready routed to s_rready[t]; on m_rvalid&&m_rready -> R_IDLE.
REQ-017 R_ERR: m_rvalid=1, m_rresp=2'b11, m_rdata=0 until m_rready; then R_IDLE.
REQ-018 Write FSM states: W_IDLE, W_ADDR, W_RESP, W_ERR.
REQ-019 W_IDLE: m_awready=m_wready=1 only when m_awvalid&&m_wvalid both high; latch addr, data, strb, target; hit -> W_ADDR, miss -> W_ERR.
REQ-020 W_ADDR: s_awvalid[t] and s_wvalid[t] asserted; each drops independently on its own ready (aw_done/w_done flags); both done -> W_RESP, flags cleared.
REQ-021 W_RESP: s_bresp/bvalid[t] routed to master, m_bready to s_bready[t]; on m_bvalid&&m_bready -> W_IDLE.
REQ-022 W_ERR: m_bvalid=1, m_bresp=2'b11 until m_bready; then W_IDLE.
REQ-023 Latency: slave valid asserts earliest one cycle after master address handshake; response passes combinationally.
REQ-024 Non-target slave valid/ready outputs are 0; unrouted data outputs are 0.
REQ-025 Master valid/ready outputs are 0 in every state not listed above.
REQ-026 Only one outstanding read and one outstanding write; new requests stall (ready=0) until FSM returns to idle.
REQ-027 Read and write to the same slave simultaneously are both forwarded; no ordering imposed between them.

Reset
REQ-028 rst forces R_IDLE, W_IDLE, clears latches and done flags next edge; in-flight transactions dropped.
REQ-029 During and after reset all s_*valid, s_*ready, m_rvalid, m_bvalid = 0; m_arready=1 from first cycle after rst deasserts.

Structure
REQ-030 Shared package ysyx_23060208_pkg holds address-map bases/limits, response codes (OKAY 2'b00, DECERR 2'b11) and FSM state encodings.
REQ-031 One sub-module ysyx_23060208_xbar_decode (combinational: address -> one-hot target + miss), instantiated once per FSM.

Verification
REQ-032 Read 0x8000_0010, SRAM returns 0xDEADBEEF OKAY -> m_rdata=0xDEADBEEF, m_rresp=00, only s_arvalid[0] ever high.
REQ-033 Write 0xA000_03F8 data 0x41 strb 0001, UART awready 2 cycles before wready -> single s_awvalid/s_wvalid pulse each, m_bresp=00.
REQ-034 Read 0x1000_0000 -> no slave valid asserted, m_rvalid=1 with m_rresp=11, m_rdata=0.
REQ-035 Concurrent read CLINT 0xA000_0048 and write SRAM 0x8000_0000 same cycle -> both complete, responses correct, no cross-routing.
REQ-036 rst asserted in R_DATA with m_rready=0 -> next cycle all valids 0, m_arready=1, subsequent read completes normally.
REQ-037 m_awvalid high with m_wvalid low 3 cycles -> m_awready stays 0 until m_wvalid rises, then both handshake same cycle.
